// File: rtl/udp_cmd_pkg.sv
// Shared types and constants for the UDP command receiver.
package udp_cmd_pkg;

  typedef enum logic [7:0] {
    OP_START   = 8'h01,
    OP_SET_EN  = 8'h02,
    OP_SET_LEN = 8'h03,
    OP_PING    = 8'h04
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_DROP,
    S_EXEC
  } state_t;

  localparam int unsigned CMD_LEN = 4;

  // A zero capture length is meaningless, so SET_LEN with arg 0 is rejected.
  function automatic logic cmd_ok(input logic [7:0] op, input logic [15:0] arg);
    logic ok;
    ok = 1'b0;
    if (op == OP_START || op == OP_SET_EN || op == OP_PING) ok = 1'b1;
    else if (op == OP_SET_LEN) ok = (arg != '0);
    return ok;
  endfunction

endpackage

// File: rtl/udp_cmd_rx_if.sv
// RX header/payload stream between eth (master) and the command receiver (slave).
interface udp_cmd_rx_if;
  logic        udp_rx_ready;
  logic        udp_hdr_valid;
  logic [15:0] udp_dest_port;
  logic [7:0]  rx_tdata;
  logic        rx_tvalid;
  logic        rx_tlast;
  logic        rx_tuser;

  modport master (
    input  udp_rx_ready,
    output udp_hdr_valid, udp_dest_port, rx_tdata, rx_tvalid, rx_tlast, rx_tuser
  );

  modport slave (
    output udp_rx_ready,
    input  udp_hdr_valid, udp_dest_port, rx_tdata, rx_tvalid, rx_tlast, rx_tuser
  );
endinterface

// File: rtl/udp_cmd_rx_sat_cnt16.sv
// Enable-driven 16-bit counter that holds at 16'hFFFF instead of wrapping.
module sat_cnt16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  count <= '0;
    else if (en && count != '1)  count <= count + 16'd1;
  end
endmodule

// File: rtl/udp_cmd_rx.sv
// Decodes 4-byte UDP command frames into ADC capture controls.
// Optional mid-frame idle timeout enabled by defining UDP_CMD_TIMEOUT_EN.
module udp_cmd_rx
  import udp_cmd_pkg::*;
#(
  parameter logic [15:0] CMD_PORT    = 16'd5000,
  parameter logic [7:0]  MAGIC       = 8'hA5,
  parameter logic [15:0] CAP_LEN_RST = 16'd1024,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  udp_cmd_rx_if.slave        bus,
  output logic               start_pulse,
  output logic               adc_en,
  output logic [15:0]        cap_len,
  output logic [15:0]        cmd_count,
  output logic [15:0]        err_count
);

  localparam logic [1:0] LAST_IDX = 2'(CMD_LEN - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] op_q, argh_q, argl_q;
  logic       ready_q;
  logic       beat;
  logic       err_inc;
  logic       cmd_inc;
  logic       timeout_hit;

  assign bus.udp_rx_ready = ready_q;
  assign beat             = bus.rx_tvalid & ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

`ifdef UDP_CMD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmr_q;
  logic          in_frame;

  assign in_frame    = (state_q == S_PAYLOAD) || (state_q == S_DROP);
  assign timeout_hit = in_frame && !beat && (tmr_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tmr_q <= '0;
    else if (in_frame && !beat) tmr_q <= tmr_q + 1'b1;
    else                       tmr_q <= '0;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_inc = 1'b0;
    cmd_inc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (bus.udp_hdr_valid)
          state_d = (bus.udp_dest_port == CMD_PORT) ? S_PAYLOAD : S_DROP;
      end
      S_PAYLOAD: begin
        if (beat) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == '0 && bus.rx_tdata != MAGIC) begin
            err_inc = 1'b1;
            state_d = bus.rx_tlast ? S_IDLE : S_DROP;
          end else if (idx_q != LAST_IDX) begin
            if (bus.rx_tlast) begin
              err_inc = 1'b1;
              state_d = S_IDLE;
            end
          end else if (!bus.rx_tlast) begin
            err_inc = 1'b1;
            state_d = S_DROP;
          end else if (bus.rx_tuser || !cmd_ok(op_q, {argh_q, bus.rx_tdata})) begin
            err_inc = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_DROP: begin
        if (beat && bus.rx_tlast) state_d = S_IDLE;
      end
      S_EXEC: begin
        cmd_inc = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout_hit) begin
      err_inc = 1'b1;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      argh_q <= '0;
      argl_q <= '0;
    end else if (state_q == S_PAYLOAD && beat) begin
      case (idx_q)
        2'd1:    op_q   <= bus.rx_tdata;
        2'd2:    argh_q <= bus.rx_tdata;
        2'd3:    argl_q <= bus.rx_tdata;
        default: ;
      endcase
    end
  end

  // Outputs are registered in EXEC so they land two cycles after the tlast beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_pulse <= 1'b0;
      adc_en      <= 1'b0;
      cap_len     <= CAP_LEN_RST;
    end else begin
      start_pulse <= cmd_inc && (op_q == OP_START);
      if (cmd_inc && op_q == OP_SET_EN)  adc_en  <= argl_q[0];
      if (cmd_inc && op_q == OP_SET_LEN) cap_len <= {argh_q, argl_q};
    end
  end

  sat_cnt16 u_cmd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cmd_inc),
    .count (cmd_count)
  );

  sat_cnt16 u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (err_inc),
    .count (err_count)
  );

endmodule
